// File: rtl/framebuffer_line_reader_pkg.sv
`default_nettype none
// ============================================================================
// framebuffer_line_reader_pkg
//   Shared SRAM / pixel types and console geometry for the framebuffer path.
//   Revision: 1.0
// ============================================================================
package framebuffer_line_reader_pkg;

   localparam int CONSOLE_COLUMNS      = 80;
   localparam int CONSOLE_ROWS         = 30;
   localparam int WIDTH_PER_CHARACTER  = 8;
   localparam int HEIGHT_PER_CHARACTER = 16;
   localparam int H_PIXELS             = CONSOLE_COLUMNS * WIDTH_PER_CHARACTER;
   localparam int V_LINES              = CONSOLE_ROWS * HEIGHT_PER_CHARACTER;

   typedef logic [19:0] SramAddress_t;
   typedef logic [15:0] SramData_t;
   typedef SramData_t   Pixel_t;

   typedef struct packed {
      logic [4:0] red;
      logic [5:0] green;
      logic [4:0] blue;
   } VgaColor_t;

   typedef struct packed {
      SramAddress_t address;
      logic         den;
      logic         oe_n;
      logic         we_n;
      SramData_t    dout;
   } SramRequest_t;

   typedef struct packed {
      logic      done;
      SramData_t din;
   } SramResult_t;

   // 640 = 512 + 128, so the line offset needs only two shifts and an adder
   function automatic SramAddress_t line_offset_640(input SramAddress_t line);
      return (line << 9) + (line << 7);
   endfunction

endpackage
`default_nettype wire

// File: rtl/framebuffer_line_reader_if.sv
`default_nettype none
// ============================================================================
// framebuffer_line_reader_if
//   Fetch control, SRAM request/result and display read port of the reader.
//   Revision: 1.0
// ============================================================================
interface framebuffer_line_reader_if #(
   parameter int COL_W  = 10,
   parameter int LINE_W = 9
);
   import framebuffer_line_reader_pkg::*;

   logic              fetchStart;
   logic [LINE_W-1:0] fetchLine;
   SramAddress_t      baseAddress;
   logic              fetchBusy;
   logic              fetchDone;
   logic              fetchOverrun;
   SramRequest_t      ramRequest;
   SramResult_t       ramResult;
   logic              bufferSwap;
   logic [COL_W-1:0]  readColumn;
   Pixel_t            readPixel;

   modport master (
      output fetchStart, fetchLine, baseAddress, ramResult, bufferSwap, readColumn,
      input  fetchBusy, fetchDone, fetchOverrun, ramRequest, readPixel
   );

   modport slave (
      input  fetchStart, fetchLine, baseAddress, ramResult, bufferSwap, readColumn,
      output fetchBusy, fetchDone, fetchOverrun, ramRequest, readPixel
   );

endinterface
`default_nettype wire

// File: rtl/framebuffer_line_reader_line_buffer_2bank.sv
`default_nettype none
// ============================================================================
// line_buffer_2bank
//   Ping-pong scanline store: two simple dual-port banks, registered read.
//   Revision: 1.0
// ============================================================================
module line_buffer_2bank
   import framebuffer_line_reader_pkg::*;
#(
   parameter int H_PIXELS = framebuffer_line_reader_pkg::H_PIXELS,
   parameter int COL_W    = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic             wr_bank,
   input  logic [COL_W-1:0] wr_addr,
   input  Pixel_t           wr_data,
   input  logic             rd_bank,
   input  logic [COL_W-1:0] rd_addr,
   output Pixel_t           rd_data
);

   Pixel_t           w_q [2];
   logic [COL_W-1:0] w_rd_idx;
   logic             r_sel;
   logic             r_zero;

   assign w_rd_idx = (rd_addr < COL_W'(H_PIXELS)) ? rd_addr : '0;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      Pixel_t mem [H_PIXELS];
      Pixel_t r_q;

      always_ff @(posedge clk) begin
         if (wr_en && (wr_bank == 1'(b))) begin
            mem[wr_addr] <= wr_data;
         end
         r_q <= mem[w_rd_idx];
      end

      assign w_q[b] = r_q;
   end

   // Bank select and range flag travel alongside the RAM output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel  <= 1'b0;
         r_zero <= 1'b1;
      end else begin
         r_sel  <= rd_bank;
         r_zero <= (rd_addr >= COL_W'(H_PIXELS));
      end
   end

   assign rd_data = r_zero ? '0 : w_q[r_sel];

endmodule
`default_nettype wire

// File: rtl/framebuffer_line_reader.sv
`default_nettype none
// ============================================================================
// framebuffer_line_reader
//   Fetches one scanline from SRAM into a ping-pong buffer for the VGA stage.
//   Revision: 1.0
// ============================================================================
module framebuffer_line_reader
   import framebuffer_line_reader_pkg::*;
#(
   parameter int H_PIXELS = framebuffer_line_reader_pkg::H_PIXELS,
   parameter int V_LINES  = framebuffer_line_reader_pkg::V_LINES,
   parameter int COL_W    = 10,
   parameter int LINE_W   = 9
) (
   input  logic                      clk,
   input  logic                      rst_n,
   framebuffer_line_reader_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [COL_W-1:0]  r_col;
   SramAddress_t      r_addr;
   logic              r_wr_bank;
   logic              r_disp_bank;
   logic              r_overrun;
   logic              r_den;
   logic              r_oe_n;
   logic              r_done;
   logic              r_busy;
   logic              w_accept;
   logic              w_wr_en;
   logic              w_last;
   logic [LINE_W-1:0] w_line;
   SramAddress_t      w_line_ext;
   SramAddress_t      w_offset;
   SramAddress_t      w_start_addr;
   SramRequest_t      w_req;

   assign w_line     = (bus.fetchLine >= LINE_W'(V_LINES)) ? LINE_W'(V_LINES - 1) : bus.fetchLine;
   assign w_line_ext = SramAddress_t'(w_line);

   if (H_PIXELS == 640) begin : g_shift_add
      assign w_offset = line_offset_640(w_line_ext);
   end else begin : g_generic_width
      assign w_offset = w_line_ext * SramAddress_t'(H_PIXELS);
   end

   assign w_start_addr = bus.baseAddress + w_offset;
   assign w_last       = (r_col == COL_W'(H_PIXELS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_wr_en  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.fetchStart) begin
               w_accept = 1'b1;
               w_next   = READ;
            end
         end
         READ: begin
            if (bus.ramResult.done) begin
               w_wr_en = 1'b1;
               w_next  = w_last ? DONE : GAP;
            end
         end
         GAP:     w_next = READ;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up with r_state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col       <= '0;
         r_addr      <= '0;
         r_wr_bank   <= 1'b0;
         r_disp_bank <= 1'b0;
         r_overrun   <= 1'b0;
         r_den       <= 1'b0;
         r_oe_n      <= 1'b1;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_den  <= (w_next == READ);
         r_oe_n <= (w_next != READ);
         r_done <= (w_next == DONE);
         r_busy <= (w_next != IDLE);

         if (bus.bufferSwap) begin
            r_disp_bank <= ~r_disp_bank;
         end

         if (w_accept) begin
            r_overrun <= 1'b0;
         end else if (bus.bufferSwap && r_busy) begin
            r_overrun <= 1'b1;
         end

         if (w_accept) begin
            r_col     <= '0;
            r_addr    <= w_start_addr;
            r_wr_bank <= ~r_disp_bank;
         end else if (w_wr_en && !w_last) begin
            r_col  <= r_col + COL_W'(1);
            r_addr <= r_addr + SramAddress_t'(1);
         end
      end
   end

   always_comb begin
      w_req         = '0;
      w_req.address = r_addr;
      w_req.den     = r_den;
      w_req.oe_n    = r_oe_n;
      w_req.we_n    = 1'b1;
      w_req.dout    = '0;
   end

   assign bus.ramRequest   = w_req;
   assign bus.fetchBusy    = r_busy;
   assign bus.fetchDone    = r_done;
   assign bus.fetchOverrun = r_overrun;

   line_buffer_2bank #(
      .H_PIXELS (H_PIXELS),
      .COL_W    (COL_W)
   ) u_line_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (w_wr_en),
      .wr_bank (r_wr_bank),
      .wr_addr (r_col),
      .wr_data (bus.ramResult.din),
      .rd_bank (r_disp_bank),
      .rd_addr (bus.readColumn),
      .rd_data (bus.readPixel)
   );

endmodule
`default_nettype wire
